// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes, FSM encoding
// and the two-requester grant helper.
package alu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SLL   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_LAND  = 3'b011;
  localparam logic [2:0] ALU_GE    = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Tie break: fixed priority favours requester 0, otherwise the one not served last.
  function automatic logic pick_grant(input logic [NUM_REQ-1:0] vld,
                                      input logic             last,
                                      input logic             fixed);
    if (vld == 2'b11) return fixed ? 1'b0 : ~last;
    return vld[1];
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational shared ALU: add, shift-left, and, logical-and, unsigned >=, pass B.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int                SHW    = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:   result = a + b;
      // the whole B is the shift amount, so anything past the width clears
      ALU_SLL:   result = (b >= SH_LIM) ? '0 : (a << b[SHW-1:0]);
      ALU_AND:   result = a & b;
      ALU_LAND:  result = {{(DATA_W-1){1'b0}}, ((|a) && (|b))};
      ALU_GE:    result = {{(DATA_W-1){1'b0}}, (a >= b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: grant, operand steering, and a
// one-deep registered response per owner with valid/ready backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_ctrl,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_ctrl,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  output logic              busy
);

  logic [NUM_REQ-1:0]             req_valid, resp_ready, req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a, req_b;
  logic [NUM_REQ-1:0][2:0]        req_ctrl;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_a      = {req1_a, req0_a};
  assign req_b      = {req1_b, req0_b};
  assign req_ctrl   = {req1_ctrl, req0_ctrl};

  state_t                         state;
  logic                           owner, last_grant;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] result_q;
  logic [NUM_REQ-1:0]             zero_q;

  logic              can_accept, accept, grant;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]        alu_ctrl;
  logic              alu_zero;

  // A held response frees the slot in the same cycle its owner takes it.
  assign can_accept = (state == ST_IDLE) || resp_ready[owner];
  assign grant      = pick_grant(req_valid, last_grant, FIXED_PRIO);
  assign accept     = can_accept && (|req_valid);
  assign req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;

  assign alu_a    = accept ? req_a[grant]    : '0;
  assign alu_b    = accept ? req_b[grant]    : '0;
  assign alu_ctrl = accept ? req_ctrl[grant] : ALU_ADD;

  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      resp_valid <= '0;
      result_q   <= '0;
      zero_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state           <= ST_RESP;
            owner           <= grant;
            last_grant      <= grant;
            resp_valid      <= NUM_REQ'(1) << grant;
            result_q[grant] <= alu_result;
            zero_q[grant]   <= alu_zero;
          end
        end
        ST_RESP: begin
          if (accept) begin
            owner           <= grant;
            last_grant      <= grant;
            resp_valid      <= NUM_REQ'(1) << grant;
            result_q[grant] <= alu_result;
            zero_q[grant]   <= alu_zero;
          end else if (resp_ready[owner]) begin
            state      <= ST_IDLE;
            resp_valid <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready   = req_ready[0];
  assign req1_ready   = req_ready[1];
  assign resp0_valid  = resp_valid[0];
  assign resp1_valid  = resp_valid[1];
  assign resp0_result = result_q[0];
  assign resp1_result = result_q[1];
  assign resp0_zero   = zero_q[0];
  assign resp1_zero   = zero_q[1];
  assign busy         = (state == ST_RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model; a second instance covers fixed priority.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req1_valid = 0, resp0_ready = 0, resp1_ready = 0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_ctrl = '0, req1_ctrl = '0;

  logic         req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_zero, resp1_zero, busy;
  logic [W-1:0] resp0_result, resp1_result;
  logic         fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
  logic         fp_resp0_zero, fp_resp1_zero, fp_busy;
  logic [W-1:0] fp_resp0_result, fp_resp1_result;

  alu_arbiter #(.DATA_W(W), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero), .busy(busy)
  );

  alu_arbiter #(.DATA_W(W), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(fp_resp0_result), .resp0_zero(fp_resp0_zero),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(fp_resp1_result), .resp1_zero(fp_resp1_zero), .busy(fp_busy)
  );

  typedef struct {
    bit           own;
    logic [W-1:0] res;
    bit           z;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // model: is a response outstanding, whose is it, who was served last
  bit m_held = 0, m_owner = 0, m_last = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] wide;
    case (c)
      3'd0: begin wide = 64'(a) + 64'(b); return wide[W-1:0]; end
      3'd1: begin
        if (b > 31) return '0;
        wide = 64'(a) * (64'd1 << b);
        return wide[W-1:0];
      end
      3'd2: return a & b;
      3'd3: return (a != 0 && b != 0) ? 1 : 0;
      3'd4: return (a >= b) ? 1 : 0;
      3'd5: return b;
      default: return '0;
    endcase
  endfunction

  task automatic step(input bit v0, input logic [2:0] c0, input logic [W-1:0] a0,
                      input logic [W-1:0] b0, input bit r0,
                      input bit v1, input logic [2:0] c1, input logic [W-1:0] a1,
                      input logic [W-1:0] b1, input bit r1);
    bit   can, g;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0; resp0_ready = r0;
    req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1; resp1_ready = r1;
    #1;
    chk("busy", busy, m_held);
    can = !m_held || (m_owner ? r1 : r0);
    g   = (v0 && v1) ? !m_last : v1;
    chk("req0_ready", req0_ready, can && (v0 || v1) && !g);
    chk("req1_ready", req1_ready, can && (v0 || v1) && g);
    if (can && (v0 || v1)) begin
      e.own = g;
      e.res = g ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
      e.z   = (e.res == 0);
      sbq.push_back(e);
      m_last = g; m_owner = g; m_held = 1;
    end else if (can) begin
      m_held = 0;
    end
  endtask

  task automatic idle(input bit r0, input bit r1);
    step(0, 3'd0, '0, '0, r0, 0, 3'd0, '0, '0, r1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    @(posedge clk); #1;
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result0", resp0_result, 0);
    chk("rst_result1", resp1_result, 0);
    chk("rst_zero", {resp1_zero, resp0_zero}, 0);
    chk("rst_fp_busy", fp_busy, 0);
    rst_n = 1;
    m_held = 0; m_owner = 0; m_last = 1;
    sbq.delete();
  endtask

  // Monitor: compares whatever response is presented with the oldest expected
  // one, and retires it on the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("valid_onehot", resp0_valid & resp1_valid, 0);
      if (resp0_valid || resp1_valid) begin
        if (sbq.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          e = sbq[0];
          chk("resp_owner", resp1_valid, e.own);
          chk("resp_result", resp1_valid ? resp1_result : resp0_result, e.res);
          chk("resp_zero", resp1_valid ? resp1_zero : resp0_zero, e.z);
          if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready))
            void'(sbq.pop_front());
        end
      end
    end
  end

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    do_reset();

    // single add
    step(1, ALU_ADD, 5, 7, 1, 0, ALU_ADD, 0, 0, 1);
    chk("single_ready0", req0_ready, 1);
    idle(1, 1);
    idle(1, 1);

    // round-robin tie, fixed-priority instance sees the same traffic
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, ALU_AND, 32'hF0, 32'h0F, 1, 1, ALU_PASSB, 0, 32'h1234, 1);
      chk("rr_grant1", req1_ready, (i % 2));
      chk("fp_ready0", fp_req0_ready, 1);
      chk("fp_ready1", fp_req1_ready, 0);
    end
    idle(1, 1);
    idle(1, 1);

    // backpressure on owner 0 while requester 1 waits
    do_reset();
    step(1, ALU_SLL, 3, 2, 0, 1, ALU_PASSB, 0, 55, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, ALU_ADD, 0, 0, 0, 1, ALU_PASSB, 0, 55, 0);
      chk("bp_ready1_low", req1_ready, 0);
      chk("bp_hold", resp0_result, 12);
    end
    step(0, ALU_ADD, 0, 0, 1, 1, ALU_PASSB, 0, 55, 0);
    chk("bp_accept1", req1_ready, 1);
    idle(1, 1);
    idle(1, 1);

    // reset while requester 1 holds a response
    step(0, ALU_ADD, 0, 0, 0, 1, ALU_GE, 9, 4, 0);
    idle(0, 0);
    chk("mid_resp1_valid", resp1_valid, 1);
    chk("mid_resp1_result", resp1_result, 1);
    do_reset();
    step(1, ALU_ADD, 1, 1, 1, 1, ALU_ADD, 2, 2, 1);
    chk("post_rst_grant0", req0_ready, 1);
    idle(1, 1);
    idle(1, 1);

    // add wrap and oversize shift
    step(1, ALU_ADD, 32'hFFFF_FFFF, 1, 1, 0, ALU_ADD, 0, 0, 1);
    step(1, ALU_SLL, 1, 32, 1, 0, ALU_ADD, 0, 0, 1);
    idle(1, 1);
    idle(1, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(),
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) idle(1, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
